// File: rtl/mem_access_unit_if.sv
// Bus between the MEM-stage access unit and the data memory: a single-beat
// request/acknowledge cycle with byte-lane enables.
interface mem_access_unit_if;
    logic        cyc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output cyc, we, addr, sel, wdata,
        input  ack, rdata
    );

    modport slave (
        input  cyc, we, addr, sel, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one handshaked bus cycle per aligned load/store,
// stalling the pipeline until ack or timeout; other ops pass through one register stage.
module mem_access_unit #(
    parameter int unsigned BIG_ENDIAN     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    mem_access_unit_if.master bus,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_req_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam logic [7:0] LB_OP  = 8'b1110_0000;
    localparam logic [7:0] LBU_OP = 8'b1110_0100;
    localparam logic [7:0] LH_OP  = 8'b1110_0001;
    localparam logic [7:0] LHU_OP = 8'b1110_0101;
    localparam logic [7:0] LW_OP  = 8'b1110_0011;
    localparam logic [7:0] SB_OP  = 8'b1110_1000;
    localparam logic [7:0] SH_OP  = 8'b1110_1001;
    localparam logic [7:0] SW_OP  = 8'b1110_1011;

    localparam logic       BE      = (BIG_ENDIAN != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e      state, state_nx;
    size_e       size, size_q;
    logic        is_mem, is_store, is_signed, signed_q;
    logic        misaligned, accept, timed_out;
    logic [3:0]  sel;
    logic [31:0] store_data, load_data;
    logic [1:0]  lo_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        is_mem    = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (aluop_i)
            LB_OP:   begin size = SZ_BYTE; is_signed = 1'b1; end
            LBU_OP:  size = SZ_BYTE;
            LH_OP:   begin size = SZ_HALF; is_signed = 1'b1; end
            LHU_OP:  size = SZ_HALF;
            LW_OP:   size = SZ_WORD;
            SB_OP:   begin size = SZ_BYTE; is_store = 1'b1; end
            SH_OP:   begin size = SZ_HALF; is_store = 1'b1; end
            SW_OP:   begin size = SZ_WORD; is_store = 1'b1; end
            default: is_mem = 1'b0;
        endcase
    end

    assign misaligned = is_mem && (((size == SZ_HALF) && mem_addr_i[0]) ||
                                   ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00)));
    assign accept     = (state == S_IDLE) && valid_i && is_mem && !misaligned;
    assign timed_out  = (state == S_BUS) && !bus.ack && (cnt == TO_LAST);

    // Big-endian puts address offset 0 in the most significant lane.
    always_comb begin
        sel        = 4'b1111;
        store_data = reg2_i;
        case (size)
            SZ_BYTE: begin
                sel        = BE ? (4'b1000 >> mem_addr_i[1:0]) : (4'b0001 << mem_addr_i[1:0]);
                store_data = {4{reg2_i[7:0]}};
            end
            SZ_HALF: begin
                sel        = (mem_addr_i[1] ^ BE) ? 4'b1100 : 4'b0011;
                store_data = {2{reg2_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_lane = lo_q ^ {2{BE}};
    assign half_lane = lo_q[1] ^ BE;
    assign rd_byte   = bus.rdata[{byte_lane, 3'b000} +: 8];
    assign rd_half   = bus.rdata[{half_lane, 4'b0000} +: 16];

    always_comb begin
        load_data = bus.rdata;
        case (size_q)
            SZ_BYTE: load_data = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
            SZ_HALF: load_data = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        stall_req_o = 1'b0;
        bus.cyc     = 1'b0;
        case (state)
            S_IDLE: begin
                stall_req_o = accept;
                if (accept) state_nx = S_BUS;
            end
            S_BUS: begin
                bus.cyc     = 1'b1;
                stall_req_o = 1'b1;
                if (bus.ack)        state_nx = S_DONE;
                else if (timed_out) state_nx = S_IDLE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lo_q       <= '0;
            size_q     <= SZ_WORD;
            signed_q   <= 1'b0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            cnt        <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        addr_q   <= {mem_addr_i[31:2], 2'b00};
                        sel_q    <= sel;
                        we_q     <= is_store;
                        wdata_q  <= store_data;
                        lo_q     <= mem_addr_i[1:0];
                        size_q   <= size;
                        signed_q <= is_signed;
                        wd_q     <= wd_i;
                        wreg_q   <= wreg_i;
                        wreg_o   <= 1'b0;
                    end else if (is_mem) begin
                        // Reaching here with valid_i high means the access was misaligned.
                        misalign_o <= valid_i;
                        wreg_o     <= 1'b0;
                    end else begin
                        wd_o    <= wd_i;
                        wreg_o  <= wreg_i & valid_i;
                        wdata_o <= wdata_i;
                    end
                end
                S_BUS: begin
                    if (bus.ack) begin
                        if (!we_q) wdata_o <= load_data;
                        wd_o   <= wd_q;
                        wreg_o <= wreg_q & ~we_q;
                    end else if (timed_out) begin
                        bus_err_o <= 1'b1;
                        wreg_o    <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: wreg_o <= 1'b0;
            endcase
        end
    end

    assign bus.addr  = addr_q;
    assign bus.sel   = sel_q;
    assign bus.we    = we_q;
    assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of load/store/pass-through
// vectors with a scoreboard, plus timeout, reset and stray-ack sequences.
module tb_mem_access_unit;

    localparam logic [7:0] LB_OP   = 8'b1110_0000;
    localparam logic [7:0] LBU_OP  = 8'b1110_0100;
    localparam logic [7:0] LH_OP   = 8'b1110_0001;
    localparam logic [7:0] LHU_OP  = 8'b1110_0101;
    localparam logic [7:0] LW_OP   = 8'b1110_0011;
    localparam logic [7:0] SB_OP   = 8'b1110_1000;
    localparam logic [7:0] SH_OP   = 8'b1110_1001;
    localparam logic [7:0] SW_OP   = 8'b1110_1011;
    localparam logic [7:0] ADDU_OP = 8'b0010_0001;
    localparam int         TO      = 4;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          ack_wait;
        logic [4:0]  wd;
        logic [31:0] alu;
        logic        exp_bus;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
        logic        exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic        misalign_o;
    logic        bus_err_o;

    mem_access_unit_if bus ();

    mem_access_unit #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .bus         (bus),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(logic [7:0] op, logic [31:0] addr, logic [31:0] reg2,
                                logic [31:0] rdata, int aw, logic [4:0] wd, logic [31:0] alu,
                                logic eb, logic [3:0] es, logic ew, logic [31:0] ebw,
                                logic [31:0] ewd, logic ewr, logic em);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.ack_wait = aw;
        v.wd = wd; v.alu = alu; v.exp_bus = eb; v.exp_sel = es; v.exp_we = ew;
        v.exp_bwdata = ebw; v.exp_wdata = ewd; v.exp_wreg = ewr; v.exp_mis = em;
        return v;
    endfunction

    // Drive one instruction, play the bus slave, and score the write-back cycle.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t  e;
        int    nbus;
        int    nstall;
        bit    done;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        valid_i = 1'b1; aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2;
        wd_i = v.wd; wreg_i = 1'b1; wdata_i = v.alu;
        bus.ack = 1'b0;
        exp_q.push_back(v);
        #1;
        nstall = stall_req_o ? 1 : 0;
        nbus   = 0;
        done   = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(posedge clk); #1;
            if (bus.cyc) begin
                check({tag, " addr"}, bus.addr, {v.addr[31:2], 2'b00});
                check({tag, " sel"}, {28'b0, bus.sel}, {28'b0, v.exp_sel});
                check({tag, " we"}, {31'b0, bus.we}, {31'b0, v.exp_we});
                if (v.exp_we) check({tag, " bus_wdata"}, bus.wdata, v.exp_bwdata);
                nbus++;
                if (stall_req_o) nstall++;
                if (nbus == v.ack_wait + 1) begin
                    bus.ack = 1'b1; bus.rdata = v.rdata;
                end else begin
                    bus.ack = 1'b0; bus.rdata = ~v.rdata;
                end
            end else if (stall_req_o) begin
                nstall++;
                bus.ack = 1'b0;
            end else begin
                bus.ack = 1'b0;
                e = exp_q.pop_front();
                check({tag, " wreg_o"}, {31'b0, wreg_o}, {31'b0, e.exp_wreg});
                check({tag, " misalign_o"}, {31'b0, misalign_o}, {31'b0, e.exp_mis});
                if (e.exp_wreg) begin
                    check({tag, " wdata_o"}, wdata_o, e.exp_wdata);
                    check({tag, " wd_o"}, {27'b0, wd_o}, {27'b0, e.wd});
                end
                check({tag, " bus cycles"}, nbus, e.exp_bus ? e.ack_wait + 1 : 0);
                check({tag, " stall cycles"}, nstall, e.exp_bus ? e.ack_wait + 2 : 0);
                done = 1'b1;
            end
        end
        check({tag, " completed"}, {31'b0, done}, 32'd1);
        valid_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " bubble wreg_o"}, {31'b0, wreg_o}, 32'd0);
        check({tag, " bubble misalign_o"}, {31'b0, misalign_o}, 32'd0);
        check({tag, " bubble cyc"}, {31'b0, bus.cyc}, 32'd0);
    endtask

    initial begin
        int  ncyc;
        bit  err_seen;
        bit  wreg_seen;

        // op, addr, reg2, rdata, ack_wait, wd, alu, bus, sel, we, bus_wdata, wdata_o, wreg_o, misalign
        vecs.push_back(mk(LW_OP,   32'h100, 32'h1111_1111, 32'hDEAD_BEEF, 2, 5'd1,  0, 1, 4'b1111, 0, 0, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk(LB_OP,   32'h101, 32'h0,         32'h1280_3456, 0, 5'd2,  0, 1, 4'b0100, 0, 0, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk(LBU_OP,  32'h101, 32'h0,         32'h1280_3456, 1, 5'd3,  0, 1, 4'b0100, 0, 0, 32'h0000_0080, 1, 0));
        vecs.push_back(mk(LH_OP,   32'h102, 32'h0,         32'h1234_8765, 0, 5'd4,  0, 1, 4'b0011, 0, 0, 32'hFFFF_8765, 1, 0));
        vecs.push_back(mk(LHU_OP,  32'h100, 32'h0,         32'h8765_1234, 0, 5'd5,  0, 1, 4'b1100, 0, 0, 32'h0000_8765, 1, 0));
        vecs.push_back(mk(LB_OP,   32'h103, 32'h0,         32'hAAAA_AA7F, 1, 5'd6,  0, 1, 4'b0001, 0, 0, 32'h0000_007F, 1, 0));
        vecs.push_back(mk(LB_OP,   32'h100, 32'h0,         32'h9A55_55FF, 0, 5'd7,  0, 1, 4'b1000, 0, 0, 32'hFFFF_FF9A, 1, 0));
        vecs.push_back(mk(LHU_OP,  32'h106, 32'h0,         32'h1234_FFEE, 0, 5'd8,  0, 1, 4'b0011, 0, 0, 32'h0000_FFEE, 1, 0));
        vecs.push_back(mk(SH_OP,   32'h102, 32'h0000_ABCD, 32'h0,         0, 5'd9,  0, 1, 4'b0011, 1, 32'hABCD_ABCD, 0, 0, 0));
        vecs.push_back(mk(SB_OP,   32'h101, 32'h1234_56EF, 32'h0,         1, 5'd10, 0, 1, 4'b0100, 1, 32'hEFEF_EFEF, 0, 0, 0));
        vecs.push_back(mk(SW_OP,   32'h204, 32'hCAFE_F00D, 32'h0,         2, 5'd11, 0, 1, 4'b1111, 1, 32'hCAFE_F00D, 0, 0, 0));
        vecs.push_back(mk(LW_OP,   32'h103, 32'h0,         32'h0,         0, 5'd12, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(LH_OP,   32'h101, 32'h0,         32'h0,         0, 5'd13, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(SW_OP,   32'h102, 32'h5555_5555, 32'h0,         0, 5'd14, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(ADDU_OP, 32'h0,   32'h0,         32'h0,         0, 5'd3,  5, 0, 4'b0000, 0, 0, 32'h5, 1, 0));

        rst = 1'b1; valid_i = 1'b0; aluop_i = '0; mem_addr_i = '0; reg2_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; bus.ack = 1'b0; bus.rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cyc", {31'b0, bus.cyc}, 32'd0);
        check("reset stall", {31'b0, stall_req_o}, 32'd0);
        check("reset wreg_o", {31'b0, wreg_o}, 32'd0);
        check("reset wdata_o", wdata_o, 32'd0);
        check("reset wd_o", {27'b0, wd_o}, 32'd0);
        check("reset misalign_o", {31'b0, misalign_o}, 32'd0);
        check("reset bus_err_o", {31'b0, bus_err_o}, 32'd0);
        check("reset sel", {28'b0, bus.sel}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);
        check("scoreboard drained", exp_q.size(), 0);

        // Ack while idle must be ignored.
        @(negedge clk);
        valid_i = 1'b0; aluop_i = LW_OP; mem_addr_i = 32'h100;
        bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        #1 check("stray ack stall", {31'b0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        check("stray ack cyc", {31'b0, bus.cyc}, 32'd0);
        check("stray ack wreg_o", {31'b0, wreg_o}, 32'd0);
        bus.ack = 1'b0;

        // Timeout with no ack.
        @(negedge clk);
        valid_i = 1'b1; aluop_i = LW_OP; mem_addr_i = 32'h300; wd_i = 5'd9; wreg_i = 1'b1;
        ncyc = 0; err_seen = 1'b0; wreg_seen = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (bus.cyc) begin
                ncyc++;
            end else begin
                err_seen  = bus_err_o;
                wreg_seen = wreg_o;
                break;
            end
        end
        check("timeout cyc cycles", ncyc, TO);
        check("timeout bus_err_o", {31'b0, err_seen}, 32'd1);
        check("timeout wreg_o", {31'b0, wreg_seen}, 32'd0);
        valid_i = 1'b0;
        #1 check("timeout stall", {31'b0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        check("timeout err pulse", {31'b0, bus_err_o}, 32'd0);
        check("timeout idle cyc", {31'b0, bus.cyc}, 32'd0);

        // Reset in the middle of a bus cycle, then a pass-through op.
        @(negedge clk);
        valid_i = 1'b1; aluop_i = LW_OP; mem_addr_i = 32'h400; bus.ack = 1'b0;
        @(posedge clk); #1;
        check("pre-reset cyc", {31'b0, bus.cyc}, 32'd1);
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        check("mid reset cyc", {31'b0, bus.cyc}, 32'd0);
        check("mid reset stall", {31'b0, stall_req_o}, 32'd0);
        check("mid reset wreg_o", {31'b0, wreg_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b1; aluop_i = ADDU_OP; wdata_i = 32'h5; wd_i = 5'd3; wreg_i = 1'b1;
        #1 check("post reset stall", {31'b0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        check("post reset wdata_o", wdata_o, 32'h5);
        check("post reset wd_o", {27'b0, wd_o}, 32'd3);
        check("post reset wreg_o", {31'b0, wreg_o}, 32'd1);
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("post reset bubble", {31'b0, wreg_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
